log_mem_arb: RTL and testbench
==============================

LOG_MEM_ARB -- requirements
Module: log_mem_arb

Interface
REQ-001 Parameter LOG_ADDR_W, default 10, log-entry index width.
REQ-002 Parameter LOG_ENTRY_W, default 256, log-entry width in bits.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 commit_rd_req_val/commit_rd_req_rdy  in/out  1/1  commit-engine read request handshake; commit_rd_req_addr  in  LOG_ADDR_W.
REQ-006 commit_rd_resp_val/commit_rd_resp_rdy  out/in  1/1  read-response handshake; commit_rd_resp_data  out  LOG_ENTRY_W.
REQ-007 commit_wr_val/commit_wr_rdy  in/out  1/1  commit-engine write handshake; commit_wr_addr  in  LOG_ADDR_W; commit_wr_data  in  LOG_ENTRY_W.
REQ-008 prep_wr_val/prep_wr_rdy  in/out  1/1  prepare-engine append handshake; prep_wr_addr  in  LOG_ADDR_W; prep_wr_data  in  LOG_ENTRY_W.
REQ-009 mem_rd_req_val/mem_rd_req_rdy  out/in  1/1  memory read request; mem_rd_req_addr  out  LOG_ADDR_W.
REQ-010 mem_rd_resp_val/mem_rd_resp_rdy  in/out  1/1  memory read response; mem_rd_resp_data  in  LOG_ENTRY_W.
REQ-011 mem_wr_val/mem_wr_rdy  out/in  1/1  memory write; mem_wr_addr  out  LOG_ADDR_W; mem_wr_data  out  LOG_ENTRY_W.
REQ-012 arb_idle  out  1  high when no read outstanding, no response held, no grant pending.

Function
REQ-013 Requesters: CR (commit read), CW (commit write), PW (prepare write); at most one memory request (read or write) issued per cycle.
REQ-014 Arbitration round-robin in fixed order CR->CW->PW; winner is first eligible requester after last_grant; last_grant updates only on accepted transfer.
REQ-015 Once a winner's memory val is asserted and not accepted, grant SHALL be held on that requester (val and addr/data stable) until accepted.
REQ-016 Memory val SHALL never depend combinationally on any memory rdy.
REQ-017 Requester rdy = (granted) & (corresponding memory rdy); requester data/addr passed through unregistered while granted.
REQ-018 Read FSM states: IDLE (no read outstanding), RD_OUT (read accepted by memory, awaiting response), RESP_HOLD (response captured, presenting to commit).
REQ-019 IDLE->RD_OUT on CR accepted; RD_OUT->RESP_HOLD on mem_rd_resp_val (mem_rd_resp_rdy=1 only in RD_OUT); RESP_HOLD->IDLE on commit_rd_resp_val & commit_rd_resp_rdy.
REQ-020 Response registered: capture mem_rd_resp_data in RD_OUT, commit_rd_resp_val=1 only in RESP_HOLD; read latency = memory latency + 1 cycle.
REQ-021 CR ineligible unless FSM in IDLE (single outstanding read).
REQ-022 Hazard: PW ineligible while FSM not IDLE and prep_wr_addr equals captured outstanding read address; CW never blocked.
REQ-023 Simultaneous CR, CW, PW with last_grant=PW: grant CR; next CW; then PW (if no hazard).
REQ-024 Ineligible requesters skipped without advancing last_grant; no requester starves beyond two accepted transfers of others.
REQ-025 arb_idle = (FSM==IDLE) & no held grant.

Reset
REQ-026 On rst low: FSM=IDLE, last_grant=PW, held grant cleared, captured address/data=0, all val and rdy outputs=0, arb_idle=1 after release.
REQ-027 Reset mid-read discards outstanding read; any later stale mem_rd_resp_val in IDLE is not accepted (mem_rd_resp_rdy=0).

Structure
REQ-028 Requester-id enum (CR, CW, PW) and read-FSM state enum SHALL live in shared package vr_log_pkg with LOG_ADDR_W/LOG_ENTRY_W defaults.
REQ-029 Round-robin selection SHALL be sub-module rr_arb3 (3 requests, last_grant in, one-hot grant out), purely combinational; holding/pointer state in log_mem_arb.

Verification
REQ-030 CR addr 0x005 alone, mem 2-cycle read latency, data 0xAA.. -> commit_rd_resp_val 3 cycles after mem accept with data 0xAA.., FSM back to IDLE after handshake.
REQ-031 CR, CW(0x010), PW(0x011) all valid from reset, all rdy high -> memory order CR, CW, PW on consecutive cycles.
REQ-032 Read 0x020 outstanding, PW to 0x020 -> prep_wr_rdy=0 until response consumed; PW to 0x021 in same window -> accepted.
REQ-033 mem_wr_rdy low 4 cycles with CW granted, PW asserted meanwhile -> mem_wr_addr/data stay CW values until accepted; PW issued next.
REQ-034 Second CR while RESP_HOLD and commit_rd_resp_rdy=0 -> commit_rd_req_rdy=0, mem_rd_req_val=0 until response taken.
REQ-035 rst asserted in RD_OUT, mem later returns response -> mem_rd_resp_rdy=0, commit_rd_resp_val=0, arb_idle=1.

Source files
------------

// File: rtl/vr_log_pkg.sv
// Shared types for the log-memory arbiter.
//   - req_id_e   : requester identity (commit read, commit write, prepare write)
//   - rd_state_e : read-path state (idle, read outstanding, response held)
//   - next_req() : round-robin successor in the fixed order CR -> CW -> PW -> CR
//   - req_onehot(): requester id to one-hot grant vector (bit0=CR, bit1=CW, bit2=PW)
package vr_log_pkg;

    localparam int unsigned LOG_ADDR_W_DEF  = 10;
    localparam int unsigned LOG_ENTRY_W_DEF = 256;

    typedef enum logic [1:0] {
        ReqCr = 2'd0,
        ReqCw = 2'd1,
        ReqPw = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRdOut    = 2'd1,
        StRespHold = 2'd2
    } rd_state_e;

    function automatic req_id_e next_req(input req_id_e id);
        case (id)
            ReqCr:   return ReqCw;
            ReqCw:   return ReqPw;
            default: return ReqCr;
        endcase
    endfunction

    function automatic logic [2:0] req_onehot(input req_id_e id);
        case (id)
            ReqCr:   return 3'b001;
            ReqCw:   return 3'b010;
            ReqPw:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin selector, purely combinational.
// Ports:
//   i_req        : eligible requests, bit0=CR, bit1=CW, bit2=PW
//   i_last_grant : requester that won the most recent accepted transfer
//   o_grant      : one-hot grant to the first eligible requester after i_last_grant
module rr_arb3
    import vr_log_pkg::*;
(
    input  logic [2:0] i_req,
    input  req_id_e    i_last_grant,
    output logic [2:0] o_grant
);

    req_id_e    w_p0;
    req_id_e    w_p1;
    req_id_e    w_p2;
    logic [2:0] w_oh0;
    logic [2:0] w_oh1;
    logic [2:0] w_oh2;

    always_comb begin
        // Search order starts just after the last winner; the last winner comes last.
        w_p0  = next_req(i_last_grant);
        w_p1  = next_req(w_p0);
        w_p2  = next_req(w_p1);
        w_oh0 = req_onehot(w_p0);
        w_oh1 = req_onehot(w_p1);
        w_oh2 = req_onehot(w_p2);

        o_grant = 3'b000;
        if (|(i_req & w_oh0)) begin
            o_grant = w_oh0;
        end else if (|(i_req & w_oh1)) begin
            o_grant = w_oh1;
        end else if (|(i_req & w_oh2)) begin
            o_grant = w_oh2;
        end
    end

endmodule

// File: rtl/log_mem_arb.sv
// Arbitrates a single log memory between the commit engine (reads and writes) and the
// prepare engine (appends). One memory request per cycle; a single read may be outstanding.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   commit_rd_req_*          : commit read request (val/rdy/addr)
//   commit_rd_resp_*         : registered read response to commit (val/rdy/data)
//   commit_wr_*              : commit write (val/rdy/addr/data)
//   prep_wr_*                : prepare append (val/rdy/addr/data)
//   mem_rd_req_*, mem_rd_resp_*, mem_wr_* : memory side
//   arb_idle                 : no read in flight, no response held, no grant pending
module log_mem_arb
    import vr_log_pkg::*;
#(
    parameter int unsigned LOG_ADDR_W  = LOG_ADDR_W_DEF,
    parameter int unsigned LOG_ENTRY_W = LOG_ENTRY_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   commit_rd_req_val,
    output logic                   commit_rd_req_rdy,
    input  logic [LOG_ADDR_W-1:0]  commit_rd_req_addr,

    output logic                   commit_rd_resp_val,
    input  logic                   commit_rd_resp_rdy,
    output logic [LOG_ENTRY_W-1:0] commit_rd_resp_data,

    input  logic                   commit_wr_val,
    output logic                   commit_wr_rdy,
    input  logic [LOG_ADDR_W-1:0]  commit_wr_addr,
    input  logic [LOG_ENTRY_W-1:0] commit_wr_data,

    input  logic                   prep_wr_val,
    output logic                   prep_wr_rdy,
    input  logic [LOG_ADDR_W-1:0]  prep_wr_addr,
    input  logic [LOG_ENTRY_W-1:0] prep_wr_data,

    output logic                   mem_rd_req_val,
    input  logic                   mem_rd_req_rdy,
    output logic [LOG_ADDR_W-1:0]  mem_rd_req_addr,

    input  logic                   mem_rd_resp_val,
    output logic                   mem_rd_resp_rdy,
    input  logic [LOG_ENTRY_W-1:0] mem_rd_resp_data,

    output logic                   mem_wr_val,
    input  logic                   mem_wr_rdy,
    output logic [LOG_ADDR_W-1:0]  mem_wr_addr,
    output logic [LOG_ENTRY_W-1:0] mem_wr_data,

    output logic                   arb_idle
);

    rd_state_e              r_state;
    rd_state_e              w_state_next;
    req_id_e                r_last_grant;
    logic                   r_hold;
    req_id_e                r_hold_id;
    logic [LOG_ADDR_W-1:0]  r_rd_addr;
    logic [LOG_ENTRY_W-1:0] r_rd_data;

    logic                   w_hazard;
    logic [2:0]             w_elig;
    logic [2:0]             w_arb_grant;
    logic [2:0]             w_grant;
    req_id_e                w_grant_id;
    logic                   w_acc;
    logic                   w_capture;

    // Appends to the entry being read would race the read; commit writes are trusted.
    assign w_hazard = (r_state != StIdle) && (prep_wr_addr == r_rd_addr);
    assign w_elig   = {prep_wr_val & ~w_hazard,
                       commit_wr_val,
                       commit_rd_req_val & (r_state == StIdle)};

    rr_arb3 u_rr_arb3 (
        .i_req        (w_elig),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant)
    );

    // A held grant overrides arbitration so memory val/addr/data stay stable until taken.
    // Grants are forced low while in reset since they are combinational from the inputs.
    always_comb begin
        w_grant = 3'b000;
        if (rst) begin
            w_grant = r_hold ? (req_onehot(r_hold_id) & w_elig) : w_arb_grant;
        end
        w_grant_id = ReqCr;
        if (w_grant[1]) begin
            w_grant_id = ReqCw;
        end else if (w_grant[2]) begin
            w_grant_id = ReqPw;
        end
    end

    // Memory-side request path; no memory val depends on any memory rdy.
    assign mem_rd_req_val  = w_grant[0];
    assign mem_rd_req_addr = w_grant[0] ? commit_rd_req_addr : '0;
    assign mem_wr_val      = w_grant[1] | w_grant[2];
    assign mem_wr_addr     = w_grant[1] ? commit_wr_addr :
                             w_grant[2] ? prep_wr_addr   : '0;
    assign mem_wr_data     = w_grant[1] ? commit_wr_data :
                             w_grant[2] ? prep_wr_data   : '0;

    assign commit_rd_req_rdy = w_grant[0] & mem_rd_req_rdy;
    assign commit_wr_rdy     = w_grant[1] & mem_wr_rdy;
    assign prep_wr_rdy       = w_grant[2] & mem_wr_rdy;
    assign w_acc             = commit_rd_req_rdy | commit_wr_rdy | prep_wr_rdy;

    // Read FSM: next state and state-derived outputs.
    always_comb begin
        w_state_next       = r_state;
        mem_rd_resp_rdy    = 1'b0;
        commit_rd_resp_val = 1'b0;
        w_capture          = 1'b0;
        case (r_state)
            StIdle: begin
                if (commit_rd_req_rdy) begin
                    w_state_next = StRdOut;
                end
            end
            StRdOut: begin
                mem_rd_resp_rdy = 1'b1;
                if (mem_rd_resp_val) begin
                    w_capture    = 1'b1;
                    w_state_next = StRespHold;
                end
            end
            StRespHold: begin
                commit_rd_resp_val = 1'b1;
                if (commit_rd_resp_rdy) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign commit_rd_resp_data = r_rd_data;
    assign arb_idle            = (r_state == StIdle) & ~r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_last_grant <= ReqPw;
            r_hold       <= 1'b0;
            r_hold_id    <= ReqCr;
            r_rd_addr    <= '0;
            r_rd_data    <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= (|w_grant) & ~w_acc;
            if ((|w_grant) & ~w_acc) begin
                r_hold_id <= w_grant_id;
            end
            if (w_acc) begin
                r_last_grant <= w_grant_id;
            end
            if (commit_rd_req_rdy) begin
                r_rd_addr <= commit_rd_req_addr;
            end
            if (w_capture) begin
                r_rd_data <= mem_rd_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_log_mem_arb.sv
// Directed bench for log_mem_arb. Expected memory transactions and read responses are
// queued in the order they must appear; a monitor pops and compares on each handshake.
module tb_log_mem_arb;

    localparam int unsigned AW           = 10;
    localparam int unsigned DW           = 256;
    localparam int          TMO          = 50;
    localparam int          RSP_HOLD_MAX = 8;

    logic          clk;
    logic          rst;
    logic          commit_rd_req_val, commit_rd_req_rdy;
    logic [AW-1:0] commit_rd_req_addr;
    logic          commit_rd_resp_val, commit_rd_resp_rdy;
    logic [DW-1:0] commit_rd_resp_data;
    logic          commit_wr_val, commit_wr_rdy;
    logic [AW-1:0] commit_wr_addr;
    logic [DW-1:0] commit_wr_data;
    logic          prep_wr_val, prep_wr_rdy;
    logic [AW-1:0] prep_wr_addr;
    logic [DW-1:0] prep_wr_data;
    logic          mem_rd_req_val, mem_rd_req_rdy;
    logic [AW-1:0] mem_rd_req_addr;
    logic          mem_rd_resp_val, mem_rd_resp_rdy;
    logic [DW-1:0] mem_rd_resp_data;
    logic          mem_wr_val, mem_wr_rdy;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          arb_idle;

    log_mem_arb #(
        .LOG_ADDR_W  (AW),
        .LOG_ENTRY_W (DW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .commit_rd_req_val   (commit_rd_req_val),
        .commit_rd_req_rdy   (commit_rd_req_rdy),
        .commit_rd_req_addr  (commit_rd_req_addr),
        .commit_rd_resp_val  (commit_rd_resp_val),
        .commit_rd_resp_rdy  (commit_rd_resp_rdy),
        .commit_rd_resp_data (commit_rd_resp_data),
        .commit_wr_val       (commit_wr_val),
        .commit_wr_rdy       (commit_wr_rdy),
        .commit_wr_addr      (commit_wr_addr),
        .commit_wr_data      (commit_wr_data),
        .prep_wr_val         (prep_wr_val),
        .prep_wr_rdy         (prep_wr_rdy),
        .prep_wr_addr        (prep_wr_addr),
        .prep_wr_data        (prep_wr_data),
        .mem_rd_req_val      (mem_rd_req_val),
        .mem_rd_req_rdy      (mem_rd_req_rdy),
        .mem_rd_req_addr     (mem_rd_req_addr),
        .mem_rd_resp_val     (mem_rd_resp_val),
        .mem_rd_resp_rdy     (mem_rd_resp_rdy),
        .mem_rd_resp_data    (mem_rd_resp_data),
        .mem_wr_val          (mem_wr_val),
        .mem_wr_rdy          (mem_wr_rdy),
        .mem_wr_addr         (mem_wr_addr),
        .mem_wr_data         (mem_wr_data),
        .arb_idle            (arb_idle)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_txn_t;

    mem_txn_t      exp_mem[$];
    logic [DW-1:0] exp_rsp[$];
    int            n_vec  = 0;
    int            n_miss = 0;
    int            rsp_lat;
    logic [DW-1:0] rsp_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DW-1:0] pat(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [AW-1:0] a);
        mem_txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = '0;
        exp_mem.push_back(t);
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        exp_mem.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester drivers: raise val, wait (bounded) for rdy, drop val after the accepting edge.
    task automatic req_cr(input logic [AW-1:0] a);
        logic seen = 1'b0;
        commit_rd_req_val  = 1'b1;
        commit_rd_req_addr = a;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (commit_rd_req_rdy) begin seen = 1'b1; break; end
        end
        chk_b("cr_handshake", seen, 1'b1);
        step();
        commit_rd_req_val = 1'b0;
    endtask

    task automatic req_cw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic seen = 1'b0;
        commit_wr_val  = 1'b1;
        commit_wr_addr = a;
        commit_wr_data = d;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (commit_wr_rdy) begin seen = 1'b1; break; end
        end
        chk_b("cw_handshake", seen, 1'b1);
        step();
        commit_wr_val = 1'b0;
    endtask

    task automatic req_pw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic seen = 1'b0;
        prep_wr_val  = 1'b1;
        prep_wr_addr = a;
        prep_wr_data = d;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (prep_wr_rdy) begin seen = 1'b1; break; end
        end
        chk_b("pw_handshake", seen, 1'b1);
        step();
        prep_wr_val = 1'b0;
    endtask

    task automatic drain(input string name);
        logic empty = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            if (exp_mem.size() == 0 && exp_rsp.size() == 0) begin empty = 1'b1; break; end
            @(posedge clk);
        end
        chk_b(name, empty, 1'b1);
        step();
    endtask

    task automatic chk_quiet(input string tag);
        chk_b({tag, "_mem_rd_req_val"}, mem_rd_req_val, 1'b0);
        chk_b({tag, "_mem_wr_val"}, mem_wr_val, 1'b0);
        chk_b({tag, "_commit_rd_req_rdy"}, commit_rd_req_rdy, 1'b0);
        chk_b({tag, "_commit_wr_rdy"}, commit_wr_rdy, 1'b0);
        chk_b({tag, "_prep_wr_rdy"}, prep_wr_rdy, 1'b0);
        chk_b({tag, "_mem_rd_resp_rdy"}, mem_rd_resp_rdy, 1'b0);
        chk_b({tag, "_commit_rd_resp_val"}, commit_rd_resp_val, 1'b0);
    endtask

    // Memory read model: answers each accepted read after rsp_lat cycles, holds the
    // response until taken or RSP_HOLD_MAX cycles elapse.
    initial begin
        mem_rd_resp_val  = 1'b0;
        mem_rd_resp_data = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_req_val && mem_rd_req_rdy) begin
                @(posedge clk);
                repeat (rsp_lat - 1) @(posedge clk);
                #1;
                mem_rd_resp_val  = 1'b1;
                mem_rd_resp_data = rsp_data;
                for (int n = 0; n < RSP_HOLD_MAX; n++) begin
                    @(negedge clk);
                    if (mem_rd_resp_rdy) break;
                end
                @(posedge clk);
                #1;
                mem_rd_resp_val = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        mem_txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_rd_req_val && mem_rd_req_rdy) begin
                    chk_b("mem_rd_expected", exp_mem.size() != 0, 1'b1);
                    if (exp_mem.size() != 0) begin
                        t = exp_mem.pop_front();
                        chk_b("mem_rd_kind", 1'b0, t.wr);
                        chk_a("mem_rd_addr", mem_rd_req_addr, t.addr);
                    end
                end
                if (mem_wr_val && mem_wr_rdy) begin
                    chk_b("mem_wr_expected", exp_mem.size() != 0, 1'b1);
                    if (exp_mem.size() != 0) begin
                        t = exp_mem.pop_front();
                        chk_b("mem_wr_kind", 1'b1, t.wr);
                        chk_a("mem_wr_addr", mem_wr_addr, t.addr);
                        chk_d("mem_wr_data", mem_wr_data, t.data);
                    end
                end
                if (commit_rd_resp_val && commit_rd_resp_rdy) begin
                    chk_b("rsp_expected", exp_rsp.size() != 0, 1'b1);
                    if (exp_rsp.size() != 0) begin
                        chk_d("rsp_data", commit_rd_resp_data, exp_rsp.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        logic seen;
        rst                = 1'b0;
        commit_rd_req_val  = 1'b0;
        commit_rd_req_addr = '0;
        commit_rd_resp_rdy = 1'b1;
        commit_wr_val      = 1'b0;
        commit_wr_addr     = '0;
        commit_wr_data     = '0;
        prep_wr_val        = 1'b0;
        prep_wr_addr       = '0;
        prep_wr_data       = '0;
        mem_rd_req_rdy     = 1'b1;
        mem_wr_rdy         = 1'b1;
        rsp_lat            = 2;
        rsp_data           = pat(32'h3030_3030);

        // Reset outputs, then all three requesters valid from reset: CR, CW, PW in order.
        exp_rd(10'h030);
        exp_wr(10'h010, pat(32'h1111_0010));
        exp_wr(10'h011, pat(32'h2222_0011));
        exp_rsp.push_back(pat(32'h3030_3030));
        fork
            req_cr(10'h030);
            req_cw(10'h010, pat(32'h1111_0010));
            req_pw(10'h011, pat(32'h2222_0011));
            begin
                @(negedge clk);
                chk_quiet("reset");
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(negedge clk);
                chk_b("rr_c1_rd_val", mem_rd_req_val, 1'b1);
                chk_b("rr_c1_wr_val", mem_wr_val, 1'b0);
                chk_b("rr_c1_arb_idle", arb_idle, 1'b1);
                @(negedge clk);
                chk_b("rr_c2_wr_val", mem_wr_val, 1'b1);
                chk_a("rr_c2_wr_addr", mem_wr_addr, 10'h010);
                @(negedge clk);
                chk_a("rr_c3_wr_addr", mem_wr_addr, 10'h011);
                chk_b("rr_c3_pw_rdy", prep_wr_rdy, 1'b1);
            end
        join
        drain("drain_rr");

        // Single read, 2-cycle memory latency: response valid 3 cycles after accept.
        rsp_lat  = 2;
        rsp_data = pat(32'hAAAA_AAAA);
        exp_rd(10'h005);
        exp_rsp.push_back(pat(32'hAAAA_AAAA));
        req_cr(10'h005);
        lat = 0;
        for (int n = 1; n <= TMO; n++) begin
            @(negedge clk);
            if (commit_rd_resp_val) begin lat = n; break; end
        end
        chk_i("rd_latency", lat, 3);
        @(negedge clk);
        chk_b("rd_done_idle", arb_idle, 1'b1);
        chk_b("rd_done_resp_val", commit_rd_resp_val, 1'b0);
        drain("drain_rd");

        // Hazard: PW to the outstanding read address blocked, other address passes.
        rsp_lat            = 6;
        rsp_data           = pat(32'h2020_2020);
        commit_rd_resp_rdy = 1'b0;
        exp_rd(10'h020);
        exp_wr(10'h021, pat(32'h5555_0021));
        exp_wr(10'h020, pat(32'h6666_0020));
        exp_rsp.push_back(pat(32'h2020_2020));
        req_cr(10'h020);
        prep_wr_val  = 1'b1;
        prep_wr_addr = 10'h020;
        prep_wr_data = pat(32'h6666_0020);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_b("hz_blocked_rdy", prep_wr_rdy, 1'b0);
            chk_b("hz_blocked_wr_val", mem_wr_val, 1'b0);
            step();
        end
        prep_wr_val = 1'b0;
        req_pw(10'h021, pat(32'h5555_0021));
        prep_wr_val  = 1'b1;
        prep_wr_addr = 10'h020;
        prep_wr_data = pat(32'h6666_0020);
        seen = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (commit_rd_resp_val) begin seen = 1'b1; break; end
            chk_b("hz_wait_rdy", prep_wr_rdy, 1'b0);
        end
        chk_b("hz_resp_held", seen, 1'b1);
        chk_b("hz_hold_rdy", prep_wr_rdy, 1'b0);
        step();
        commit_rd_resp_rdy = 1'b1;
        @(negedge clk);
        chk_b("hz_consume_rdy", prep_wr_rdy, 1'b0);
        step();
        @(negedge clk);
        chk_b("hz_release_rdy", prep_wr_rdy, 1'b1);
        chk_a("hz_release_addr", mem_wr_addr, 10'h020);
        step();
        prep_wr_val = 1'b0;
        drain("drain_hz");

        // Held grant: CW stalled by mem_wr_rdy while PW (next in rotation) waits.
        exp_wr(10'h03F, pat(32'h7777_003F));
        exp_wr(10'h040, pat(32'h8888_0040));
        exp_wr(10'h041, pat(32'h9999_0041));
        req_cw(10'h03F, pat(32'h7777_003F));
        mem_wr_rdy     = 1'b0;
        commit_wr_val  = 1'b1;
        commit_wr_addr = 10'h040;
        commit_wr_data = pat(32'h8888_0040);
        @(negedge clk);
        chk_a("hold_first_addr", mem_wr_addr, 10'h040);
        step();
        prep_wr_val  = 1'b1;
        prep_wr_addr = 10'h041;
        prep_wr_data = pat(32'h9999_0041);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_b("hold_wr_val", mem_wr_val, 1'b1);
            chk_a("hold_wr_addr", mem_wr_addr, 10'h040);
            chk_d("hold_wr_data", mem_wr_data, pat(32'h8888_0040));
            chk_b("hold_pw_rdy", prep_wr_rdy, 1'b0);
            chk_b("hold_arb_idle", arb_idle, 1'b0);
            step();
        end
        mem_wr_rdy = 1'b1;
        @(negedge clk);
        chk_b("hold_cw_rdy", commit_wr_rdy, 1'b1);
        chk_a("hold_cw_addr", mem_wr_addr, 10'h040);
        step();
        commit_wr_val = 1'b0;
        @(negedge clk);
        chk_b("hold_pw_next_rdy", prep_wr_rdy, 1'b1);
        chk_a("hold_pw_next_addr", mem_wr_addr, 10'h041);
        step();
        prep_wr_val = 1'b0;
        drain("drain_hold");

        // Second CR while a response is held: not issued until the response is taken.
        rsp_lat            = 2;
        rsp_data           = pat(32'h5050_5050);
        commit_rd_resp_rdy = 1'b0;
        exp_rd(10'h050);
        exp_rsp.push_back(pat(32'h5050_5050));
        exp_rd(10'h051);
        exp_rsp.push_back(pat(32'h5151_5151));
        req_cr(10'h050);
        seen = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (commit_rd_resp_val) begin seen = 1'b1; break; end
        end
        chk_b("cr2_resp_held", seen, 1'b1);
        step();
        rsp_data           = pat(32'h5151_5151);
        commit_rd_req_val  = 1'b1;
        commit_rd_req_addr = 10'h051;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_b("cr2_req_rdy", commit_rd_req_rdy, 1'b0);
            chk_b("cr2_mem_rd_val", mem_rd_req_val, 1'b0);
            chk_b("cr2_resp_val", commit_rd_resp_val, 1'b1);
            step();
        end
        commit_rd_resp_rdy = 1'b1;
        @(negedge clk);
        chk_b("cr2_take_req_rdy", commit_rd_req_rdy, 1'b0);
        step();
        @(negedge clk);
        chk_b("cr2_issue_rdy", commit_rd_req_rdy, 1'b1);
        chk_a("cr2_issue_addr", mem_rd_req_addr, 10'h051);
        step();
        commit_rd_req_val = 1'b0;
        drain("drain_cr2");

        // Reset with a read outstanding; the late memory response must be ignored.
        rsp_lat  = 6;
        rsp_data = pat(32'h6060_6060);
        exp_rd(10'h060);
        req_cr(10'h060);
        @(negedge clk);
        chk_b("rst_rdout_resp_rdy", mem_rd_resp_rdy, 1'b1);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("midrst");
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (mem_rd_resp_val) begin seen = 1'b1; break; end
        end
        chk_b("stale_resp_seen", seen, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk_b("stale_resp_rdy", mem_rd_resp_rdy, 1'b0);
            chk_b("stale_commit_val", commit_rd_resp_val, 1'b0);
            chk_b("stale_arb_idle", arb_idle, 1'b1);
            @(negedge clk);
        end
        for (int n = 0; n < TMO; n++) begin
            if (!mem_rd_resp_val) break;
            @(posedge clk);
        end
        chk_b("stale_resp_dropped", mem_rd_resp_val, 1'b0);
        step();

        chk_i("exp_mem_left", exp_mem.size(), 0);
        chk_i("exp_rsp_left", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
